// File: rtl/sbox_sub_word_iter.sv
// rtl/sbox_sub_word_iter.sv - AES forward SubWord/RotWord/Rcon unit, one S-box lookup per cycle
// Iterates a shared forward S-box over four buffer bytes, then applies Rcon on the finishing cycle.
module sbox_sub_word_iter #(
  parameter int          DATA_W    = 32,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] in0,
  input  logic              rot_en,
  input  logic              rcon_en,
  output logic [DATA_W-1:0] out0,
  output logic              done,
  output logic [7:0]        rcon
);

  if (DATA_W != 32) begin : g_bad_width
    $error("sbox_sub_word_iter: only DATA_W=32 is supported");
  end

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               rce_q, rce_d;
  logic               done_q, done_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [7:0]         rcon_eff;
  logic [7:0]         sub_in, sub_out;

  // A run pulse overrides the stored Rcon in the same cycle, so FIN sees the reloaded value.
  assign rcon_eff = run ? RCON_INIT : rcon_q;
  assign sub_in   = buf_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    sub_out = 8'h00;
    case (sub_in)
      8'h00: sub_out = 8'h63; 8'h01: sub_out = 8'h7c; 8'h02: sub_out = 8'h77; 8'h03: sub_out = 8'h7b; 8'h04: sub_out = 8'hf2; 8'h05: sub_out = 8'h6b; 8'h06: sub_out = 8'h6f; 8'h07: sub_out = 8'hc5;
      8'h08: sub_out = 8'h30; 8'h09: sub_out = 8'h01; 8'h0a: sub_out = 8'h67; 8'h0b: sub_out = 8'h2b; 8'h0c: sub_out = 8'hfe; 8'h0d: sub_out = 8'hd7; 8'h0e: sub_out = 8'hab; 8'h0f: sub_out = 8'h76;
      8'h10: sub_out = 8'hca; 8'h11: sub_out = 8'h82; 8'h12: sub_out = 8'hc9; 8'h13: sub_out = 8'h7d; 8'h14: sub_out = 8'hfa; 8'h15: sub_out = 8'h59; 8'h16: sub_out = 8'h47; 8'h17: sub_out = 8'hf0;
      8'h18: sub_out = 8'had; 8'h19: sub_out = 8'hd4; 8'h1a: sub_out = 8'ha2; 8'h1b: sub_out = 8'haf; 8'h1c: sub_out = 8'h9c; 8'h1d: sub_out = 8'ha4; 8'h1e: sub_out = 8'h72; 8'h1f: sub_out = 8'hc0;
      8'h20: sub_out = 8'hb7; 8'h21: sub_out = 8'hfd; 8'h22: sub_out = 8'h93; 8'h23: sub_out = 8'h26; 8'h24: sub_out = 8'h36; 8'h25: sub_out = 8'h3f; 8'h26: sub_out = 8'hf7; 8'h27: sub_out = 8'hcc;
      8'h28: sub_out = 8'h34; 8'h29: sub_out = 8'ha5; 8'h2a: sub_out = 8'he5; 8'h2b: sub_out = 8'hf1; 8'h2c: sub_out = 8'h71; 8'h2d: sub_out = 8'hd8; 8'h2e: sub_out = 8'h31; 8'h2f: sub_out = 8'h15;
      8'h30: sub_out = 8'h04; 8'h31: sub_out = 8'hc7; 8'h32: sub_out = 8'h23; 8'h33: sub_out = 8'hc3; 8'h34: sub_out = 8'h18; 8'h35: sub_out = 8'h96; 8'h36: sub_out = 8'h05; 8'h37: sub_out = 8'h9a;
      8'h38: sub_out = 8'h07; 8'h39: sub_out = 8'h12; 8'h3a: sub_out = 8'h80; 8'h3b: sub_out = 8'he2; 8'h3c: sub_out = 8'heb; 8'h3d: sub_out = 8'h27; 8'h3e: sub_out = 8'hb2; 8'h3f: sub_out = 8'h75;
      8'h40: sub_out = 8'h09; 8'h41: sub_out = 8'h83; 8'h42: sub_out = 8'h2c; 8'h43: sub_out = 8'h1a; 8'h44: sub_out = 8'h1b; 8'h45: sub_out = 8'h6e; 8'h46: sub_out = 8'h5a; 8'h47: sub_out = 8'ha0;
      8'h48: sub_out = 8'h52; 8'h49: sub_out = 8'h3b; 8'h4a: sub_out = 8'hd6; 8'h4b: sub_out = 8'hb3; 8'h4c: sub_out = 8'h29; 8'h4d: sub_out = 8'he3; 8'h4e: sub_out = 8'h2f; 8'h4f: sub_out = 8'h84;
      8'h50: sub_out = 8'h53; 8'h51: sub_out = 8'hd1; 8'h52: sub_out = 8'h00; 8'h53: sub_out = 8'hed; 8'h54: sub_out = 8'h20; 8'h55: sub_out = 8'hfc; 8'h56: sub_out = 8'hb1; 8'h57: sub_out = 8'h5b;
      8'h58: sub_out = 8'h6a; 8'h59: sub_out = 8'hcb; 8'h5a: sub_out = 8'hbe; 8'h5b: sub_out = 8'h39; 8'h5c: sub_out = 8'h4a; 8'h5d: sub_out = 8'h4c; 8'h5e: sub_out = 8'h58; 8'h5f: sub_out = 8'hcf;
      8'h60: sub_out = 8'hd0; 8'h61: sub_out = 8'hef; 8'h62: sub_out = 8'haa; 8'h63: sub_out = 8'hfb; 8'h64: sub_out = 8'h43; 8'h65: sub_out = 8'h4d; 8'h66: sub_out = 8'h33; 8'h67: sub_out = 8'h85;
      8'h68: sub_out = 8'h45; 8'h69: sub_out = 8'hf9; 8'h6a: sub_out = 8'h02; 8'h6b: sub_out = 8'h7f; 8'h6c: sub_out = 8'h50; 8'h6d: sub_out = 8'h3c; 8'h6e: sub_out = 8'h9f; 8'h6f: sub_out = 8'ha8;
      8'h70: sub_out = 8'h51; 8'h71: sub_out = 8'ha3; 8'h72: sub_out = 8'h40; 8'h73: sub_out = 8'h8f; 8'h74: sub_out = 8'h92; 8'h75: sub_out = 8'h9d; 8'h76: sub_out = 8'h38; 8'h77: sub_out = 8'hf5;
      8'h78: sub_out = 8'hbc; 8'h79: sub_out = 8'hb6; 8'h7a: sub_out = 8'hda; 8'h7b: sub_out = 8'h21; 8'h7c: sub_out = 8'h10; 8'h7d: sub_out = 8'hff; 8'h7e: sub_out = 8'hf3; 8'h7f: sub_out = 8'hd2;
      8'h80: sub_out = 8'hcd; 8'h81: sub_out = 8'h0c; 8'h82: sub_out = 8'h13; 8'h83: sub_out = 8'hec; 8'h84: sub_out = 8'h5f; 8'h85: sub_out = 8'h97; 8'h86: sub_out = 8'h44; 8'h87: sub_out = 8'h17;
      8'h88: sub_out = 8'hc4; 8'h89: sub_out = 8'ha7; 8'h8a: sub_out = 8'h7e; 8'h8b: sub_out = 8'h3d; 8'h8c: sub_out = 8'h64; 8'h8d: sub_out = 8'h5d; 8'h8e: sub_out = 8'h19; 8'h8f: sub_out = 8'h73;
      8'h90: sub_out = 8'h60; 8'h91: sub_out = 8'h81; 8'h92: sub_out = 8'h4f; 8'h93: sub_out = 8'hdc; 8'h94: sub_out = 8'h22; 8'h95: sub_out = 8'h2a; 8'h96: sub_out = 8'h90; 8'h97: sub_out = 8'h88;
      8'h98: sub_out = 8'h46; 8'h99: sub_out = 8'hee; 8'h9a: sub_out = 8'hb8; 8'h9b: sub_out = 8'h14; 8'h9c: sub_out = 8'hde; 8'h9d: sub_out = 8'h5e; 8'h9e: sub_out = 8'h0b; 8'h9f: sub_out = 8'hdb;
      8'ha0: sub_out = 8'he0; 8'ha1: sub_out = 8'h32; 8'ha2: sub_out = 8'h3a; 8'ha3: sub_out = 8'h0a; 8'ha4: sub_out = 8'h49; 8'ha5: sub_out = 8'h06; 8'ha6: sub_out = 8'h24; 8'ha7: sub_out = 8'h5c;
      8'ha8: sub_out = 8'hc2; 8'ha9: sub_out = 8'hd3; 8'haa: sub_out = 8'hac; 8'hab: sub_out = 8'h62; 8'hac: sub_out = 8'h91; 8'had: sub_out = 8'h95; 8'hae: sub_out = 8'he4; 8'haf: sub_out = 8'h79;
      8'hb0: sub_out = 8'he7; 8'hb1: sub_out = 8'hc8; 8'hb2: sub_out = 8'h37; 8'hb3: sub_out = 8'h6d; 8'hb4: sub_out = 8'h8d; 8'hb5: sub_out = 8'hd5; 8'hb6: sub_out = 8'h4e; 8'hb7: sub_out = 8'ha9;
      8'hb8: sub_out = 8'h6c; 8'hb9: sub_out = 8'h56; 8'hba: sub_out = 8'hf4; 8'hbb: sub_out = 8'hea; 8'hbc: sub_out = 8'h65; 8'hbd: sub_out = 8'h7a; 8'hbe: sub_out = 8'hae; 8'hbf: sub_out = 8'h08;
      8'hc0: sub_out = 8'hba; 8'hc1: sub_out = 8'h78; 8'hc2: sub_out = 8'h25; 8'hc3: sub_out = 8'h2e; 8'hc4: sub_out = 8'h1c; 8'hc5: sub_out = 8'ha6; 8'hc6: sub_out = 8'hb4; 8'hc7: sub_out = 8'hc6;
      8'hc8: sub_out = 8'he8; 8'hc9: sub_out = 8'hdd; 8'hca: sub_out = 8'h74; 8'hcb: sub_out = 8'h1f; 8'hcc: sub_out = 8'h4b; 8'hcd: sub_out = 8'hbd; 8'hce: sub_out = 8'h8b; 8'hcf: sub_out = 8'h8a;
      8'hd0: sub_out = 8'h70; 8'hd1: sub_out = 8'h3e; 8'hd2: sub_out = 8'hb5; 8'hd3: sub_out = 8'h66; 8'hd4: sub_out = 8'h48; 8'hd5: sub_out = 8'h03; 8'hd6: sub_out = 8'hf6; 8'hd7: sub_out = 8'h0e;
      8'hd8: sub_out = 8'h61; 8'hd9: sub_out = 8'h35; 8'hda: sub_out = 8'h57; 8'hdb: sub_out = 8'hb9; 8'hdc: sub_out = 8'h86; 8'hdd: sub_out = 8'hc1; 8'hde: sub_out = 8'h1d; 8'hdf: sub_out = 8'h9e;
      8'he0: sub_out = 8'he1; 8'he1: sub_out = 8'hf8; 8'he2: sub_out = 8'h98; 8'he3: sub_out = 8'h11; 8'he4: sub_out = 8'h69; 8'he5: sub_out = 8'hd9; 8'he6: sub_out = 8'h8e; 8'he7: sub_out = 8'h94;
      8'he8: sub_out = 8'h9b; 8'he9: sub_out = 8'h1e; 8'hea: sub_out = 8'h87; 8'heb: sub_out = 8'he9; 8'hec: sub_out = 8'hce; 8'hed: sub_out = 8'h55; 8'hee: sub_out = 8'h28; 8'hef: sub_out = 8'hdf;
      8'hf0: sub_out = 8'h8c; 8'hf1: sub_out = 8'ha1; 8'hf2: sub_out = 8'h89; 8'hf3: sub_out = 8'h0d; 8'hf4: sub_out = 8'hbf; 8'hf5: sub_out = 8'he6; 8'hf6: sub_out = 8'h42; 8'hf7: sub_out = 8'h68;
      8'hf8: sub_out = 8'h41; 8'hf9: sub_out = 8'h99; 8'hfa: sub_out = 8'h2d; 8'hfb: sub_out = 8'h0f; 8'hfc: sub_out = 8'hb0; 8'hfd: sub_out = 8'h54; 8'hfe: sub_out = 8'hbb; 8'hff: sub_out = 8'h16;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    rce_d   = rce_q;
    out_d   = out_q;
    done_d  = 1'b0;
    rcon_d  = rcon_eff;
    ready   = (state_q == S_IDLE) && running && !rst;
    case (state_q)
      S_IDLE: begin
        if (start && running) begin
          buf_d   = rot_en ? {in0[23:0], in0[31:24]} : in0;
          rce_d   = rcon_en;
          idx_d   = 2'd0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (running) begin
          buf_d[{idx_q, 3'b000} +: 8] = sub_out;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (running) begin
          out_d   = buf_q ^ (rce_q ? {rcon_eff, 24'h0} : 32'h0);
          done_d  = 1'b1;
          // xtime: multiply by x in GF(2^8), reducing by the AES polynomial.
          if (rce_q) rcon_d = {rcon_eff[6:0], 1'b0} ^ (rcon_eff[7] ? 8'h1b : 8'h00);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      buf_q   <= '0;
      rce_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      rce_q   <= rce_d;
      out_q   <= out_d;
      done_q  <= done_d;
      rcon_q  <= rcon_d;
    end
  end

  assign out0 = out_q;
  assign done = done_q;
  assign rcon = rcon_q;

endmodule

// File: tb/tb_sbox_sub_word_iter.sv
// tb/tb_sbox_sub_word_iter.sv - self-checking bench for sbox_sub_word_iter
// Reference S-box is derived from GF(2^8) inversion plus the affine map, not from a table.
module tb_sbox_sub_word_iter;

  logic        clk, rst, run, running, start, ready, rot_en, rcon_en, done;
  logic [31:0] in0, out0;
  logic [7:0]  rcon;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_sb [256];
  logic [7:0]  dut_sb [256];
  logic [7:0]  m_rcon;

  typedef struct {
    logic [31:0] w;
    logic        rot;
    logic        rce;
    logic [31:0] exp_out;
    logic [7:0]  exp_rcon;
  } vec_t;
  vec_t vecs [4];

  sbox_sub_word_iter #(.DATA_W(32), .RCON_INIT(8'h01)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .start(start), .ready(ready),
    .in0(in0), .rot_en(rot_en), .rcon_en(rcon_en), .out0(out0), .done(done), .rcon(rcon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t = {v, v};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_word(input logic [31:0] w, input logic r, input logic c, output logic [31:0] e);
    logic [31:0] s;
    s = r ? {w[23:0], w[31:24]} : w;
    for (int b = 0; b < 4; b++) e[8*b +: 8] = ref_sb[s[8*b +: 8]];
    if (c) begin
      e[31:24] = e[31:24] ^ m_rcon;
      m_rcon = gmul(m_rcon, 8'h02);
    end
  endtask

  task automatic wait_ready;
    int g = 0;
    while (!ready && g < 20) begin tick; g++; end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 40) begin tick; lat++; end
  endtask

  task automatic do_word(input logic [31:0] w, input logic r, input logic c, input logic with_run,
                         output logic [31:0] o, output int lat);
    wait_ready;
    in0 = w; rot_en = r; rcon_en = c; start = 1'b1; run = with_run;
    tick;
    start = 1'b0; run = 1'b0;
    lat = 0;
    wait_done(lat);
    o = out0;
  endtask

  initial begin
    logic [31:0] o, e;
    int lat, done_cnt, first_done, last_done, ready_cnt;
    logic [7:0] rc_exp [10];

    for (int i = 0; i < 256; i++) ref_sb[i] = calc_sbox(8'(i));
    m_rcon = 8'h01;

    rc_exp = '{8'h62, 8'h61, 8'h67, 8'h6b, 8'h73, 8'h43, 8'h23, 8'he3, 8'h78, 8'h55};
    vecs[0] = '{32'h00010253, 1'b0, 1'b0, 32'h637c77ed, 8'h01};
    vecs[1] = '{32'h09cf4f3c, 1'b1, 1'b1, 32'h8b84eb01, 8'h02};
    vecs[2] = '{32'h53ff0100, 1'b0, 1'b0, 32'hed167c63, 8'h02};
    vecs[3] = '{32'h00000000, 1'b0, 1'b1, 32'h61636363, 8'h04};

    rst = 1'b1; run = 1'b0; running = 1'b1; start = 1'b0;
    in0 = '0; rot_en = 1'b0; rcon_en = 1'b0;
    tick; tick;
    check("rst_out0", out0, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rcon", 32'(rcon), 32'h01);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      do_word(vecs[i].w, vecs[i].rot, vecs[i].rce, 1'b0, o, lat);
      model_word(vecs[i].w, vecs[i].rot, vecs[i].rce, e);
      check($sformatf("vec%0d_out", i), o, vecs[i].exp_out);
      check($sformatf("vec%0d_model", i), o, e);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d_rcon", i), 32'(rcon), 32'(vecs[i].exp_rcon));
    end

    tick;
    check("done_one_cycle", 32'(done), 32'd0);
    tick; tick;
    check("out0_hold", out0, 32'h61636363);

    run = 1'b1; tick; run = 1'b0;
    m_rcon = 8'h01;
    check("run_reload", 32'(rcon), 32'h01);
    for (int i = 0; i < 10; i++) begin
      do_word(32'h0, 1'b0, 1'b1, 1'b0, o, lat);
      model_word(32'h0, 1'b0, 1'b1, e);
      check($sformatf("rcon_seq%0d", i), 32'(o[31:24]), 32'(rc_exp[i]));
      check($sformatf("rcon_seq%0d_low", i), 32'(o[23:0]), 32'h636363);
    end
    check("rcon_final", 32'(rcon), 32'h6c);

    wait_ready;
    in0 = 32'hdeadbeef; rot_en = 1'b0; rcon_en = 1'b0; start = 1'b1;
    done_cnt = 0; first_done = 0; last_done = 0; ready_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      tick;
      if (ready) ready_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        last_done = k;
        model_word(32'hdeadbeef, 1'b0, 1'b0, e);
        check("hold_start_out", out0, e);
      end
    end
    start = 1'b0;
    check("hold_start_dones", 32'(done_cnt), 32'd3);
    check("hold_start_first", 32'(first_done), 32'd6);
    check("hold_start_last", 32'(last_done), 32'd18);
    check("hold_start_ready", 32'(ready_cnt), 32'd3);

    wait_ready;
    in0 = 32'h0badf00d; rot_en = 1'b1; rcon_en = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    running = 1'b0;
    tick; tick; tick;
    check("stall_no_done", 32'(done), 32'd0);
    running = 1'b1;
    lat = 5;
    wait_done(lat);
    model_word(32'h0badf00d, 1'b1, 1'b0, e);
    check("stall_lat", 32'(lat), 32'd8);
    check("stall_out", out0, e);

    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      do_word(w, 1'b0, 1'b0, 1'b0, o, lat);
      model_word(w, 1'b0, 1'b0, e);
      check($sformatf("exh_word%0d", i), o, e);
      for (int b = 0; b < 4; b++) dut_sb[4*i+b] = o[8*b +: 8];
    end
    check("spot_53", 32'(dut_sb[8'h53]), 32'hed);
    check("spot_ff", 32'(dut_sb[8'hff]), 32'h16);
    check("spot_01", 32'(dut_sb[8'h01]), 32'h7c);

    // Move Rcon off its initial value so the reload cases below are observable.
    do_word(32'h11223344, 1'b0, 1'b1, 1'b0, o, lat);
    model_word(32'h11223344, 1'b0, 1'b1, e);
    check("pre_run_out", o, e);
    do_word(32'h55667788, 1'b1, 1'b1, 1'b1, o, lat);
    m_rcon = 8'h01;
    model_word(32'h55667788, 1'b1, 1'b1, e);
    check("run_with_start_out", o, e);
    check("run_with_start_rcon", 32'(rcon), 32'h02);

    wait_ready;
    in0 = 32'h99aabbcc; rot_en = 1'b0; rcon_en = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    run = 1'b1; tick; run = 1'b0;
    lat = 2;
    wait_done(lat);
    m_rcon = 8'h01;
    model_word(32'h99aabbcc, 1'b0, 1'b1, e);
    check("run_mid_sub_out", out0, e);
    check("run_mid_sub_lat", 32'(lat), 32'd5);
    check("run_mid_sub_rcon", 32'(rcon), 32'h02);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] w;
      logic r, c, wr;
      w  = $urandom;
      r  = 1'($urandom);
      c  = 1'($urandom);
      wr = ($urandom_range(0, 4) == 0);
      do_word(w, r, c, wr, o, lat);
      if (wr) m_rcon = 8'h01;
      model_word(w, r, c, e);
      check($sformatf("rand%0d_out", i), o, e);
      check($sformatf("rand%0d_rcon", i), 32'(rcon), 32'(m_rcon));
    end

    do_word(32'hcafef00d, 1'b0, 1'b1, 1'b0, o, lat);
    model_word(32'hcafef00d, 1'b0, 1'b1, e);
    check("pre_rst_out", o, e);
    wait_ready;
    in0 = 32'h01020304; rot_en = 1'b0; rcon_en = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out0", out0, 32'h0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_rcon", 32'(rcon), 32'h01);
    check("async_rst_ready", 32'(ready), 32'd0);
    tick;
    rst = 1'b0;
    m_rcon = 8'h01;
    #1;
    check("async_rst_ready_after", 32'(ready), 32'd1);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (done) lat++;
    end
    check("async_rst_no_done", 32'(lat), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_sub_word_iter.md
Name: sbox_sub_word_iter

Overview:
Forward AES SubWord/RotWord/Rcon unit for the Versat AES key-expansion datapath. It is the encrypt-direction counterpart of the inverse S-box unit. A single shared forward S-box (FIPS-197 Fig. 7 table, 256-entry combinational case) substitutes one byte per cycle. Four cycles build one 32-bit word. An internal Rcon register advances by GF(2^8) doubling after each Rcon-applied word.

Parameters:
DATA_W, 32, word width; only 32 is supported, and other values are a configuration error.
RCON_INIT, 8'h01, Rcon value loaded on reset and on run.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  1-cycle pulse at start of a Versat run; reloads Rcon to RCON_INIT
running  input  1  accelerator-active enable; FSM advances only while high
start  input  1  request to process in0; accepted only when ready=1
ready  output  1  high when the unit can accept start (IDLE and running=1)
in0  input  DATA_W  input word, MSB byte = AES byte a0
rot_en  input  1  apply RotWord before substitution; sampled on start
rcon_en  input  1  XOR Rcon into out0[31:24] and advance Rcon; sampled on start
out0  output  DATA_W  result word, held until the next completion
done  output  1  1-cycle pulse when out0 is updated
rcon  output  8  current Rcon value, for debug and verification

Behaviour:
- Reset (async, rst=1): state IDLE, out0=0, done=0, ready=0 (ready is combinational, so it goes high once rst=0 and running=1). Rcon=RCON_INIT. Byte index=0, word buffer=0.
- States: IDLE, SUB, FIN.
- IDLE:
  - ready = running.
  - start and running accepted at edge t: buffer = rot_en ? {in0[23:0],in0[31:24]} : in0. Latch rot_en and rcon_en. idx=0. Go to SUB.
- SUB:
  - Each running=1 cycle, replace buffer byte idx (idx 0 = bits 7:0, up to idx 3 = bits 31:24) with SBOX(byte), then idx++.
  - After idx 3 is written, go to FIN.
  - With running=0 the FSM holds state, idx and buffer.
- FIN (one running=1 cycle):
  - out0 = buffer ^ (rcon_en_lat ? {rcon,24'h0} : 0).
  - done=1 for exactly that cycle. Go to IDLE.
  - If rcon_en_lat: rcon = xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0). The new rcon is used by the next word, not this one.
- Latency: start accepted at edge t; SUB edges at t+1..t+4; out0 and done update at edge t+5 (all with running held high). Throughput is one word per 6 cycles, since ready is low in SUB and FIN.
- done is low in every other cycle. out0 holds its value across IDLE and across later SUB cycles until the next FIN.
- start while not ready is ignored; no queueing.
- run and start in the same cycle: Rcon reload takes priority, and the accepted word uses RCON_INIT.
- run during SUB or FIN:
  - Rcon reloads.
  - The in-flight word completes normally using the reloaded value.
  - If the in-flight word has rcon_en, Rcon then advances from the reloaded value.
- Rcon wrap: 0x80 -> 0x1b -> 0x36 -> 0x6c (standard xtime; no saturation).
- rst mid-operation: immediate abort, all state returns to its reset values, no done pulse.
- Unused upper bits: none; DATA_W=32 means out0 is fully defined.

Test Plan:
- Reset values: assert rst asynchronously mid-SUB -> out0=0, done=0 and rcon=0x01 without waiting for a clock edge. After release with running=1 -> ready=1.
- Plain SubWord: rot_en=0, rcon_en=0, in0=0x00010253 -> done exactly 5 cycles after acceptance, out0=0x637c77ed, rcon stays 0x01.
- FIPS-197 key-expansion step: rot_en=1, rcon_en=1, in0=0x09cf4f3c -> out0=0x8b84eb01, rcon becomes 0x02.
- Rcon sequence: run pulse, then 10 back-to-back words with rcon_en=1 and in0=0 (SubWord(0)=0x63636363). out0[31:24] values are 63^rc for rc = 01,02,04,08,10,20,40,80,1b,36 (i.e. 0x62,0x61,0x67,0x6b,0x73,0x43,0x23,0xe3,0x78,0x55). rcon ends at 0x6c.
- Handshake and stall:
  - start held high continuously -> one word accepted per 6 cycles, ready low during SUB and FIN.
  - running dropped for 3 cycles mid-SUB -> done is delayed by exactly 3 cycles with the same out0.
- Exhaustive table: 64 words covering bytes 0x00..0xff with rot_en=0, rcon_en=0 -> each byte equals the FIPS-197 forward S-box entry. Spot checks: 0x53->0xed, 0xff->0x16, 0x01->0x7c.
